// File: rtl/booth2_pkg.sv
// Shared constants for the radix-4 Booth code generator: triplet encodings, FSM states
// and small helpers for classifying a triplet.
package booth2_pkg;

    localparam logic [2:0] BOOTH_ZERO_P = 3'b000;
    localparam logic [2:0] BOOTH_P1A    = 3'b001;
    localparam logic [2:0] BOOTH_P1B    = 3'b010;
    localparam logic [2:0] BOOTH_P2     = 3'b011;
    localparam logic [2:0] BOOTH_M2     = 3'b100;
    localparam logic [2:0] BOOTH_M1A    = 3'b101;
    localparam logic [2:0] BOOTH_M1B    = 3'b110;
    localparam logic [2:0] BOOTH_ZERO_N = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A triplet whose partial product is zero carries no work for the datapath.
    function automatic logic booth_is_zero(input logic [2:0] t);
        return (t == BOOTH_ZERO_P) || (t == BOOTH_ZERO_N);
    endfunction

    // Signed multiple of A selected by a triplet (-2..+2).
    function automatic logic signed [2:0] booth_digit(input logic [2:0] t);
        case (t)
            BOOTH_P1A, BOOTH_P1B: return 3'sd1;
            BOOTH_P2:             return 3'sd2;
            BOOTH_M2:             return -3'sd2;
            BOOTH_M1A, BOOTH_M1B: return -3'sd1;
            default:              return 3'sd0;
        endcase
    endfunction

endpackage

// File: rtl/booth2_next_idx.sv
// Combinational next-code index: the index after idx (or the first one when "first"),
// optionally skipping zero-product triplets when BOOTH_SKIP_ZERO_EN is defined.
module booth2_next_idx
    import booth2_pkg::*;
#(
    parameter  int WIDTH     = 16,
    localparam int NUM_CODES = WIDTH / 2,
    localparam int IDX_W     = $clog2(NUM_CODES)
) (
    input  logic [WIDTH:0]     shadow,
    input  logic [IDX_W-1:0]   idx,
    input  logic               first,
    output logic [IDX_W-1:0]   next_idx
);

`ifdef BOOTH_SKIP_ZERO_EN
    // Lowest index >= lo that is non-zero; the top index always qualifies so the stream ends.
    always_comb begin
        int lo;
        lo       = first ? 0 : int'(idx) + 1;
        next_idx = IDX_W'(NUM_CODES - 1);
        for (int j = NUM_CODES - 1; j >= 0; j--) begin
            if (j >= lo && (j == NUM_CODES - 1 || !booth_is_zero(shadow[2*j +: 3])))
                next_idx = IDX_W'(j);
        end
    end
`else
    logic unused_shadow;
    assign unused_shadow = ^shadow;
    assign next_idx      = first ? '0 : idx + 1'b1;
`endif

endmodule

// File: rtl/booth2_code_gen.sv
// Radix-4 Booth encoder: accepts one B operand and streams its overlapping triplets with
// valid/ready. Define BOOTH_SKIP_ZERO_EN to drop zero-product codes (top index always sent).
module booth2_code_gen
    import booth2_pkg::*;
#(
    parameter  int WIDTH     = 16,
    localparam int NUM_CODES = WIDTH / 2,
    localparam int IDX_W     = $clog2(NUM_CODES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  B,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [2:0]        code,
    output logic [IDX_W-1:0]  code_idx,
    output logic              code_last,
    output state_t            state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // while valid is high and ready low, the payload is held unchanged.

    state_t           state_q;
    logic [WIDTH:0]   shadow_q;
    logic [WIDTH:0]   src;
    logic [IDX_W-1:0] nidx;
    logic [2:0]       ncode;
    logic             nlast;

    // In IDLE the incoming operand is looked at directly so the first code is ready next cycle.
    assign src   = (state_q == ST_IDLE) ? {B, 1'b0} : shadow_q;
    assign ncode = src[{nidx, 1'b0} +: 3];
    assign nlast = (nidx == IDX_W'(NUM_CODES - 1));

    booth2_next_idx #(.WIDTH(WIDTH)) u_next_idx (
        .shadow   (src),
        .idx      (code_idx),
        .first    (state_q == ST_IDLE),
        .next_idx (nidx)
    );

    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            in_ready   <= 1'b1;
            code_valid <= 1'b0;
            code       <= '0;
            code_idx   <= '0;
            code_last  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q    <= ST_RUN;
                        shadow_q   <= {B, 1'b0};
                        in_ready   <= 1'b0;
                        code_valid <= 1'b1;
                        code       <= ncode;
                        code_idx   <= nidx;
                        code_last  <= nlast;
                    end
                end
                ST_RUN: begin
                    if (code_ready) begin
                        if (code_last) begin
                            state_q    <= ST_IDLE;
                            in_ready   <= 1'b1;
                            code_valid <= 1'b0;
                        end else begin
                            code      <= ncode;
                            code_idx  <= nidx;
                            code_last <= nlast;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready   <= 1'b1;
                    code_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth2_code_gen.sv
// Bench for booth2_code_gen: directed and random operands checked against a triplet-extraction
// model, with backpressure, ignored-input and mid-stream reset scenarios.
module tb_booth2_code_gen;
    import booth2_pkg::*;

    localparam int WIDTH     = 16;
    localparam int NUM_CODES = WIDTH / 2;
    localparam int IDX_W     = $clog2(NUM_CODES);
    localparam int EW        = IDX_W + 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             code_ready = 1'b0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready;
    logic             code_valid;
    logic [2:0]       code;
    logic [IDX_W-1:0] code_idx;
    logic             code_last;
    state_t           state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    booth2_code_gen #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .B          (b),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code       (code),
        .code_idx   (code_idx),
        .code_last  (code_last),
        .state_dbg  (state_dbg)
    );

    // clock/reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: code i is bits [2i+1:2i-1] of B with a zero appended below bit 0.
    function automatic void model(input logic [WIDTH-1:0] val);
        int   s;
        int   t;
        logic keep;
        s = int'(val) * 2;
        for (int i = 0; i < NUM_CODES; i++) begin
            t    = (s / (4 ** i)) % 8;
            keep = 1'b1;
`ifdef BOOTH_SKIP_ZERO_EN
            keep = (t != 0 && t != 7) || (i == NUM_CODES - 1);
`endif
            if (keep)
                exp_q.push_back({IDX_W'(i), t[2:0], (i == NUM_CODES - 1)});
        end
    endfunction

    // driver: one operand, optional 3-cycle stall at stall_idx, optional random ready
    task automatic send(input logic [WIDTH-1:0] val, input int stall_idx, input bit rnd);
        int            guard;
        int            stalls;
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        model(val);
        in_valid = 1'b1;
        b        = val;
        @(negedge clk);
        in_valid = 1'b0;
        check("first_valid", 32'(code_valid), 32'd1);
        check("in_ready_run", 32'(in_ready), 32'd0);
        stalls = 0;
        guard  = 0;
        while (exp_q.size() > 0) begin
            if (guard > 300) begin
                check("stream_timeout", 32'd0, 32'd1);
                exp_q.delete();
                break;
            end
            guard++;
            e = exp_q[0];
            if (stall_idx >= 0 && int'(e[EW-1 -: IDX_W]) == stall_idx && stalls < 3) begin
                code_ready = 1'b0;
                stalls++;
            end else if (rnd) begin
                code_ready = 1'($urandom_range(0, 1));
            end else begin
                code_ready = 1'b1;
            end
            check("code_valid", 32'(code_valid), 32'd1);
            got = {code_idx, code, code_last};
            check("code", 32'(got), 32'(e));
            if (code_ready) void'(exp_q.pop_front());
            in_valid = 1'($urandom_range(0, 1));
            b        = WIDTH'($urandom);
            @(negedge clk);
        end
        in_valid   = 1'b0;
        code_ready = 1'b0;
        b          = '0;
        check("in_ready_back", 32'(in_ready), 32'd1);
        check("valid_drop", 32'(code_valid), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] dir_b [6];
        logic [EW-1:0]    got;
        int               guard;
        dir_b = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h5555, 16'hAAAA};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_code_valid", 32'(code_valid), 32'd0);
        check("rst_payload", 32'({code_idx, code, code_last}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;

        // code_ready while idle must not start anything
        code_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready_ignored", 32'(code_valid), 32'd0);
        end
        code_ready = 1'b0;

        foreach (dir_b[i]) send(dir_b[i], -1, 1'b0);
        send(16'h00C3, 1, 1'b0);
        for (int k = 0; k < 25; k++) send(WIDTH'($urandom), -1, 1'b1);

        // abort mid-stream at index 3
        model(16'h5555);
        @(negedge clk);
        in_valid = 1'b1;
        b        = 16'h5555;
        @(negedge clk);
        in_valid   = 1'b0;
        code_ready = 1'b1;
        guard      = 0;
        while (int'(exp_q[0][EW-1 -: IDX_W]) < 3 && guard < 20) begin
            got = {code_idx, code, code_last};
            check("pre_abort_code", 32'(got), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            @(negedge clk);
            guard++;
        end
        code_ready = 1'b0;
        check("pre_abort_idx", 32'(code_idx), 32'd3);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(code_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_payload", 32'({code_idx, code, code_last}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0001, -1, 1'b0);
        send(16'h8000, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
